seven_seg_scan_ctrl: RTL and testbench

Display controller for the ATM's 8-digit seven-segment panel. It holds an 8-entry digit buffer and lets two requesters write into it through a round-robin arbitrated valid/ready port: the ATM main FSM (port 0) and the keypad/PIN-entry logic (port 1). It time-multiplexes the buffer onto the active-low anodes and segments, with per-digit blanking and blinking. It replaces free-running, constant-digit scanning as the single owner of AN/led.

---
 rtl/atm_disp_pkg.sv | 15 +
 rtl/seg_hex_decode.sv | 10 +
 rtl/seven_seg_scan_ctrl.sv | 80 ++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/atm_disp_pkg.sv
// atm_disp_pkg: shared constants, digit type and segment table for the ATM display
package atm_disp_pkg;
    localparam int DIGITS = 8;
    localparam logic [4:0] BLANK = 5'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    // bit4 = blank, bits3:0 = hex value
    typedef logic [4:0] digit_t;
    // active-low {a,b,c,d,e,f,g}, indexed by hex value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex to active-low seven-segment decoder
// Ports: hex_i (4-bit value), seg_o (active-low {a,b,c,d,e,f,g})
module seg_hex_decode
    import atm_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_TABLE[hex_i];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 8-digit buffer with two round-robin write ports, scanned onto active-low AN/led
// Ports: clk/rst (async active-high); req0_* ATM FSM write port, req1_* keypad write port
//   (valid/addr/data in, ready out); clear blanks all digits; blink_en per-digit blink;
//   AN active-low one-hot anode select; led active-low segments {a..g}.
module seven_seg_scan_ctrl
    import atm_disp_pkg::*;
#(
    parameter int REFRESH_DIV_W = 17,
    parameter int BLINK_DIV_W   = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [2:0] req0_addr,
    input  logic [4:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_addr,
    input  logic [4:0] req1_data,
    output logic       req1_ready,
    input  logic       clear,
    input  logic [7:0] blink_en,
    output logic [7:0] AN,
    output logic [6:0] led
);
    logic                     rr_q, rr_d;
    digit_t                   dig_q [DIGITS];
    logic [REFRESH_DIV_W+2:0] scan_q;
    // one bit wider than BLINK_DIV_W so the MSB toggles every 2^BLINK_DIV_W clocks
    logic [BLINK_DIV_W:0]     blink_q;
    logic [7:0]               an_q;
    logic [6:0]               led_q;
    logic [2:0]               idx;
    digit_t                   cur;
    logic                     dark;
    logic [6:0]               seg;

    assign idx  = scan_q[REFRESH_DIV_W+2 -: 3];
    assign cur  = dig_q[idx];
    assign dark = cur[4] | (blink_en[idx] & blink_q[BLINK_DIV_W]);
    assign AN   = an_q;
    assign led  = led_q;

    seg_hex_decode u_dec (
        .hex_i (cur[3:0]),
        .seg_o (seg)
    );

    // rr = 0 favours port 0 on contention; it flips only after a contended grant
    always_comb begin
        req0_ready = !rst && !clear && req0_valid && (!req1_valid || !rr_q);
        req1_ready = !rst && !clear && req1_valid && (!req0_valid || rr_q);
        rr_d       = (req0_ready && req1_valid) ? 1'b1 :
                     (req1_ready && req0_valid) ? 1'b0 : rr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= 1'b0;
            scan_q  <= '0;
            blink_q <= '0;
            an_q    <= 8'hFF;
            led_q   <= SEG_OFF;
            for (int i = 0; i < DIGITS; i++) dig_q[i] <= BLANK;
        end else begin
            rr_q    <= rr_d;
            scan_q  <= scan_q + 1'b1;
            blink_q <= blink_q + 1'b1;
            an_q    <= ~(8'b1 << idx);
            led_q   <= dark ? SEG_OFF : seg;
            if (clear) begin
                for (int i = 0; i < DIGITS; i++) dig_q[i] <= BLANK;
            end else if (req0_ready) begin
                dig_q[req0_addr] <= req0_data;
            end else if (req1_ready) begin
                dig_q[req1_addr] <= req1_data;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed scoreboard bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_addr = '0, req1_addr = '0;
    logic [4:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready;
    logic       clear = 1'b0;
    logic [7:0] blink_en = '0;
    logic [7:0] AN;
    logic [6:0] led;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    bit exp_q [$];
    logic [6:0] exp_seg [8];

    seven_seg_scan_ctrl #(.REFRESH_DIV_W(2), .BLINK_DIV_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .clear(clear), .blink_en(blink_en), .AN(AN), .led(led)
    );

    always #5 clk = ~clk;

    // edges since the last reset release
    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else ncyc <= ncyc + 1;
    end

    // grant monitor: pops the expected port whenever a ready is presented
    always @(negedge clk) begin
        if (!rst) begin
            if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid)) begin
                total++; bad++;
                $display("FAIL ready_without_valid: r0=%b v0=%b r1=%b v1=%b", req0_ready, req0_valid, req1_ready, req1_valid);
            end
            if (req0_ready && req1_ready) begin
                total++; bad++;
                $display("FAIL double_grant: both readies high at %0t", $time);
            end else if (req0_ready || req1_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_grant: port %0d granted with nothing expected at %0t", req1_ready, $time);
                end else begin
                    automatic bit e = exp_q.pop_front();
                    if (req1_ready != e) begin
                        bad++;
                        $display("FAIL grant_port: got port %0d want port %0d at %0t", req1_ready, e, $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // every cycle: AN follows the scan index, led shows the expected digit or dark
    task automatic check_scan(input int cycles);
        int n, idx;
        logic [7:0] ea;
        logic [6:0] el;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            n = ncyc;
            if (n == 0) begin
                ea = 8'hFF; el = 7'h7F;
            end else begin
                idx = ((n - 1) >> 2) & 7;
                ea = ~(8'b1 << idx);
                el = (blink_en[idx] && ((((n - 1) >> 4) & 1) == 1)) ? 7'h7F : exp_seg[idx];
            end
            chk("scan_an", AN, ea);
            chk("scan_led", {1'b0, led}, {1'b0, el});
            if (n != 0) begin
                total++;
                if ($countones(~AN) != 1) begin
                    bad++;
                    $display("FAIL an_onehot: got %h at %0t", AN, $time);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_seg[i] = 7'h7F;
        #2 rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", {7'b0, req0_ready}, 8'h00);
        chk("rst_ready1", {7'b0, req1_ready}, 8'h00);
        chk("rst_an", AN, 8'hFF);
        chk("rst_led", {1'b0, led}, 8'h7F);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        check_scan(34);

        // asynchronous reset mid-scan
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_an", AN, 8'hFF);
        chk("midrst_led", {1'b0, led}, 8'h7F);
        tick();
        rst = 1'b0;
        check_scan(6);

        // single write on port 0
        tick();
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 5'h07;
        exp_q.push_back(1'b0);
        #1 chk("single_ready0", {7'b0, req0_ready}, 8'h01);
        tick();
        req0_valid = 1'b0;
        exp_seg[3] = 7'b0001111;
        tick();
        check_scan(36);

        // contention: grants alternate 0,1,0,1
        tick();
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 5'h02;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 5'h0B;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        repeat (4) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_seg[1] = 7'b0010010;
        exp_seg[2] = 7'b1100000;
        tick();
        check_scan(36);

        // clear collides with a keypad write; the write lands one cycle later
        tick();
        clear = 1'b1;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 5'h0C;
        #1;
        chk("clear_ready1", {7'b0, req1_ready}, 8'h00);
        chk("clear_ready0", {7'b0, req0_ready}, 8'h00);
        tick();
        clear = 1'b0;
        exp_q.push_back(1'b1);
        #1 chk("after_clear_ready1", {7'b0, req1_ready}, 8'h01);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_seg[i] = 7'h7F;
        exp_seg[5] = 7'b0110001;
        tick();
        check_scan(36);

        // blink on digits 0, 4 and 5
        tick();
        req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 5'h08;
        req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 5'h08;
        blink_en = 8'h31;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b0;
        exp_seg[0] = 7'b0000000;
        exp_seg[4] = 7'b0000000;
        tick();
        check_scan(70);
        blink_en = 8'h00;
        tick();
        tick();
        check_scan(36);

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_grants: got %0d outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
